if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 25 ++
 rtl/if_fetch_unit_fetch_buffer.sv | 52 +++++
 rtl/if_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared constants and types for the instruction fetch unit:
//   WORD_ZERO     - all-zero 32-bit word (NOP value of the IF/ID outputs)
//   PC_STEP       - sequential PC increment
//   fetch_state_t - fetch FSM state encoding
//   word_align()  - clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// One-entry holding register for a fetched instruction and its pc+4.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   load                - capture load_instr / load_pc_plus_4, mark valid
//   clear               - invalidate the entry (wins over load)
//   load_instr          - instruction word to capture
//   load_pc_plus_4      - pc+4 of that instruction
//   instr, pc_plus_4    - held values, forced to zero while invalid
//   valid               - entry holds a presentable instruction
// ----------------------------------------------------------------------------
module fetch_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus_4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        valid
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus_4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q     <= WORD_ZERO;
      pc_plus_4_q <= WORD_ZERO;
      valid_q     <= 1'b0;
    end else if (clear) begin
      instr_q     <= WORD_ZERO;
      pc_plus_4_q <= WORD_ZERO;
      valid_q     <= 1'b0;
    end else if (load) begin
      instr_q     <= load_instr;
      pc_plus_4_q <= load_pc_plus_4;
      valid_q     <= 1'b1;
    end
  end

  // An invalid entry presents a NOP (all zero) downstream.
  assign instr     = valid_q ? instr_q     : WORD_ZERO;
  assign pc_plus_4 = valid_q ? pc_plus_4_q : WORD_ZERO;
  assign valid     = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: owns the PC and the fetch FSM, issues one
// instruction-memory request at a time and presents the returned word to the
// IF/ID register through a one-entry holding buffer.
//
// Memory handshake: imem_req is held high with a stable imem_addr until the
// cycle in which imem_ack is 1; that cycle completes the request and
// imem_rdata is valid only then. There is no back-pressure on the response.
//
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   pc_write            - IF/ID consumes the presented instruction (0 = stall)
//   redirect            - taken branch/jump, redirect_target is the new PC
//   imem_req/imem_addr  - instruction memory request and word address
//   imem_ack/imem_rdata - memory response
//   instruction_out     - instruction presented to IF/ID (0 when not valid)
//   pc_plus_4_out       - address of that instruction plus 4 (0 when not valid)
//   pc_page_out         - pc_plus_4_out[31:28]
//   fetch_valid         - the three outputs above are valid
//   flush_out           - IF/ID flush, follows redirect combinationally
//   state_dbg           - current FSM state, for observation only
// ----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pc_write,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instruction_out,
  output logic [31:0]  pc_plus_4_out,
  output logic [3:0]   pc_page_out,
  output logic         fetch_valid,
  output logic         flush_out,
  output fetch_state_t state_dbg
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  redirect_pc;
  logic [31:0]  pc_next_seq;

  assign redirect_pc = word_align(redirect_target);
  // Plain 32-bit add wraps 0xFFFF_FFFC to 0.
  assign pc_next_seq = pc_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= word_align(RESET_PC);
      tgt_q   <= WORD_ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // In DRAIN, pc_q keeps the old address so the outstanding request stays
  // stable; the redirect target waits in tgt_q until the ack retires it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    buf_load  = 1'b0;
    buf_clear = redirect;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect) pc_d = redirect_pc;
      end
      ST_FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (pc_write) begin
          pc_d      = pc_next_seq;
          buf_clear = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          tgt_d = redirect_pc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fetch_buffer u_fetch_buffer (
    .clk            (clk),
    .rst            (rst),
    .load           (buf_load),
    .clear          (buf_clear),
    .load_instr     (imem_rdata),
    .load_pc_plus_4 (pc_next_seq),
    .instr          (instruction_out),
    .pc_plus_4      (pc_plus_4_out),
    .valid          (fetch_valid)
  );

  assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr   = pc_q;
  assign pc_page_out = pc_plus_4_out[31:28];
  assign flush_out   = redirect;
  assign state_dbg   = state_q;

endmodule
